axi4l_regfile: RTL

Parametrised AXI4-Lite slave register file, the generalised successor of the fixed-size `axi4l_regs` block. It provides NUM_REGS registers of DATA_WIDTH bits and honours WSTRB byte lanes. Each register is either software read/write or hardware-driven read-only, selected per register by a mask. It sits between the interconnect and fabric logic: register contents fan out, status fans in, and per-register access pulses are generated. Address channels are handled independently, and errors are reported with SLVERR.

---
 rtl/axi4l_regfile.sv | 123 ++++++++++++
 1 files changed

// File: rtl/axi4l_regfile.sv
// axi4l_regfile: AXI4-Lite register file with byte strobes, read-only hw slots and access pulses
module axi4l_regfile #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RST_VAL = '0
) (
  input  logic                           axi4l_aclk,
  input  logic                           axi4l_arstn,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS-1:0]            wr_pulse,
  output logic [NUM_REGS-1:0]            rd_pulse
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LB = $clog2(BYTES);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(NUM_REGS * BYTES);
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic aw_held, w_held, aw_hs, w_hs, ar_hs, commit, wr_in, wr_ok, rd_in;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data, rd_val;
  logic [BYTES-1:0] w_strb;
  logic [IW-1:0] wr_idx, rd_idx;
  logic unused;
  assign unused = ^{awprot, arprot};
  assign aw_hs = awvalid && awready;
  assign w_hs = wvalid && wready;
  assign ar_hs = arvalid && arready;
  assign commit = aw_held && w_held && (!bvalid || bready);
  assign wr_in = {1'b0, aw_addr} < SPAN;
  assign wr_idx = IW'(aw_addr >> LB);
  assign wr_ok = wr_in && !RO_MASK[wr_idx];
  assign rd_in = {1'b0, araddr} < SPAN;
  assign rd_idx = IW'(araddr >> LB);
  assign rd_val = !rd_in ? '0 : RO_MASK[rd_idx] ? hw_in[rd_idx*DATA_WIDTH +: DATA_WIDTH] : regs[rd_idx];
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : regs[g];
  end
  // ready is the registered complement of the hold, so a channel reopens on its commit edge
  always_ff @(posedge axi4l_aclk or negedge axi4l_arstn) begin
    if (!axi4l_arstn) begin
      awready  <= 1'b0;
      wready   <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_addr  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid   <= 1'b0;
      bresp    <= 2'b00;
      wr_pulse <= '0;
    end else begin
      aw_held  <= !commit && (aw_held || aw_hs);
      w_held   <= !commit && (w_held || w_hs);
      awready  <= commit || !(aw_held || aw_hs);
      wready   <= commit || !(w_held || w_hs);
      wr_pulse <= '0;
      if (aw_hs) aw_addr <= awaddr;
      if (w_hs) begin
        w_data <= wdata;
        w_strb <= wstrb;
      end
      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= wr_ok ? 2'b00 : 2'b10;
        if (wr_ok) wr_pulse[wr_idx] <= 1'b1;
      end else if (bready) begin
        bvalid <= 1'b0;
      end
    end
  end
  always_ff @(posedge axi4l_aclk or negedge axi4l_arstn) begin
    if (!axi4l_arstn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL[i*DATA_WIDTH +: DATA_WIDTH];
    end else if (commit && wr_ok) begin
      for (int k = 0; k < BYTES; k++)
        if (w_strb[k]) regs[wr_idx][k*8 +: 8] <= w_data[k*8 +: 8];
    end
  end
  // rd_val samples regs before this edge's commit lands, giving pre-write data on collision
  always_ff @(posedge axi4l_aclk or negedge axi4l_arstn) begin
    if (!axi4l_arstn) begin
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= 2'b00;
      rd_pulse <= '0;
    end else begin
      rd_pulse <= '0;
      if (ar_hs) begin
        arready <= 1'b0;
        rvalid  <= 1'b1;
        rdata   <= rd_val;
        rresp   <= rd_in ? 2'b00 : 2'b10;
        if (rd_in) rd_pulse[rd_idx] <= 1'b1;
      end else if (!rvalid || rready) begin
        arready <= 1'b1;
        rvalid  <= 1'b0;
      end
    end
  end
endmodule
